// File: rtl/pwm_channel_bank.sv
// Bank of NumChannels double-buffered PWM channels behind a simple single-cycle device bus.
// Define PWM_IRQ_EN to add the period-wrap interrupt (irq_o port and IRQ_STATUS at 0x3F0).
module pwm_channel_bank #(
    parameter int unsigned NumChannels  = 12,
    parameter int unsigned CtrSize      = 16,
    parameter int unsigned BusAddrWidth = 32,
    parameter int unsigned BusDataWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    device_req_i,
    input  logic [BusAddrWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [3:0]              device_be_i,
    input  logic [BusDataWidth-1:0] device_wdata_i,
    output logic                    device_rvalid_o,
    output logic [BusDataWidth-1:0] device_rdata_o,
    output logic [NumChannels-1:0]  pwm_o
`ifdef PWM_IRQ_EN
    ,
    output logic                    irq_o
`endif
);

    localparam logic [1:0] RegPeriod = 2'd0;
    localparam logic [1:0] RegDuty   = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegCount  = 2'd3;
`ifdef PWM_IRQ_EN
    localparam logic [5:0] IrqIdx    = 6'h3F;
`endif

    logic [CtrSize-1:0]     period_sh_q [NumChannels];
    logic [CtrSize-1:0]     duty_sh_q   [NumChannels];
    logic [CtrSize-1:0]     period_a_q  [NumChannels];
    logic [CtrSize-1:0]     duty_a_q    [NumChannels];
    logic [CtrSize-1:0]     counter_q   [NumChannels];
    logic [NumChannels-1:0] en_q;
    logic [NumChannels-1:0] inv_q;
    logic [NumChannels-1:0] wrap;
    logic [NumChannels-1:0] chan_wr;
`ifdef PWM_IRQ_EN
    logic [NumChannels-1:0] irq_en_q;
    logic [NumChannels-1:0] irq_status_q;
    logic [NumChannels-1:0] irq_status_d;
    logic [NumChannels-1:0] irq_clr;
    logic [63:0]            clr_ext;
    logic                   irq_q;
`endif

    logic [5:0]              idx;
    logic [1:0]              reg_sel;
    logic                    bus_wr;
    logic [31:0]             byte_mask;
    logic [CtrSize-1:0]      lane_mask;
    logic [CtrSize-1:0]      wdata_c;
    logic [BusDataWidth-1:0] rd_data;
    logic [BusDataWidth-1:0] rdata_q;
    logic                    rvalid_q;
    logic                    unused_bus;

    assign idx       = device_addr_i[9:4];
    assign reg_sel   = device_addr_i[3:2];
    assign bus_wr    = device_req_i && device_we_i;
    assign byte_mask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                        {8{device_be_i[1]}}, {8{device_be_i[0]}}};
    assign lane_mask = byte_mask[CtrSize-1:0];
    assign wdata_c   = device_wdata_i[CtrSize-1:0];

    // Only a slice of the address/data/mask is decoded; fold the rest away.
    assign unused_bus = ^{device_addr_i, device_wdata_i, device_be_i, byte_mask};

    always_comb begin
        for (int n = 0; n < NumChannels; n++) begin
            chan_wr[n] = bus_wr && (idx == 6'(n));
            wrap[n]    = en_q[n] && (counter_q[n] == period_a_q[n]);
            pwm_o[n]   = (en_q[n] && (counter_q[n] < duty_a_q[n])) ^ inv_q[n];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NumChannels; n++) begin
                period_sh_q[n] <= '0;
                duty_sh_q[n]   <= '0;
                period_a_q[n]  <= '0;
                duty_a_q[n]    <= '0;
                counter_q[n]   <= '0;
            end
            en_q  <= '0;
            inv_q <= '0;
`ifdef PWM_IRQ_EN
            irq_en_q <= '0;
`endif
        end else begin
            for (int n = 0; n < NumChannels; n++) begin
                if (chan_wr[n] && reg_sel == RegPeriod) begin
                    period_sh_q[n] <= (period_sh_q[n] & ~lane_mask) | (wdata_c & lane_mask);
                end
                if (chan_wr[n] && reg_sel == RegDuty) begin
                    duty_sh_q[n] <= (duty_sh_q[n] & ~lane_mask) | (wdata_c & lane_mask);
                end
                if (chan_wr[n] && reg_sel == RegCtrl && device_be_i[0]) begin
                    en_q[n]  <= device_wdata_i[0];
                    inv_q[n] <= device_wdata_i[1];
`ifdef PWM_IRQ_EN
                    irq_en_q[n] <= device_wdata_i[2];
`endif
                end
                // Active copies reload from the old shadow value, so a same-cycle write
                // lands one period later.
                if (!en_q[n] || wrap[n]) begin
                    counter_q[n]  <= '0;
                    period_a_q[n] <= period_sh_q[n];
                    duty_a_q[n]   <= duty_sh_q[n];
                end else begin
                    counter_q[n] <= counter_q[n] + CtrSize'(1);
                end
            end
        end
    end

`ifdef PWM_IRQ_EN
    // Write-1-to-clear; a wrap in the same cycle sets the bit regardless.
    always_comb begin
        clr_ext      = {32'b0, device_wdata_i & byte_mask};
        irq_clr      = (bus_wr && idx == IrqIdx && reg_sel == RegPeriod) ?
                       clr_ext[NumChannels-1:0] : '0;
        irq_status_d = (irq_status_q & ~irq_clr) | (wrap & irq_en_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_d;
        end
    end

    assign irq_o = irq_q;

    logic unused_irq;
    assign unused_irq = ^clr_ext;
`endif

    always_comb begin
        rd_data = '0;
        for (int n = 0; n < NumChannels; n++) begin
            if (idx == 6'(n)) begin
                unique case (reg_sel)
                    RegPeriod: rd_data = 32'(period_sh_q[n]);
                    RegDuty:   rd_data = 32'(duty_sh_q[n]);
                    RegCtrl: begin
                        rd_data[0] = en_q[n];
                        rd_data[1] = inv_q[n];
`ifdef PWM_IRQ_EN
                        rd_data[2] = irq_en_q[n];
`endif
                    end
                    RegCount:  rd_data = 32'(counter_q[n]);
                    default:   rd_data = '0;
                endcase
            end
        end
`ifdef PWM_IRQ_EN
        if (idx == IrqIdx && reg_sel == RegPeriod) begin
            rd_data = 32'(irq_status_q);
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= device_req_i;
            rdata_q  <= (device_req_i && !device_we_i) ? rd_data : '0;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank: bus responses go through a scoreboard queue checked by a
// monitor on rvalid; PWM waveforms are compared cycle by cycle against hand-set patterns.
module tb_pwm_channel_bank;

    localparam int NumChannels = 12;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req = 1'b0;
    logic [31:0]            addr = '0;
    logic                   we = 1'b0;
    logic [3:0]             be = '0;
    logic [31:0]            wdata = '0;
    logic                   rvalid;
    logic [31:0]            rdata;
    logic [NumChannels-1:0] pwm;
`ifdef PWM_IRQ_EN
    logic                   irq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        int          cyc;
        string       name;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    pwm_channel_bank #(
        .NumChannels (NumChannels),
        .CtrSize     (16),
        .BusAddrWidth(32),
        .BusDataWidth(32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .pwm_o          (pwm)
`ifdef PWM_IRQ_EN
        ,
        .irq_o          (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every request must produce exactly one rvalid, one cycle later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() != 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rvalid_missing"}, 32'd0, 32'd1);
            end
            if (rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_rvalid_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.chk) check(mon_e.name, rdata, mon_e.exp);
                end
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the request retired.
    task automatic bus(input bit w, input logic [9:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit chk, input logic [31:0] exp,
                       input string name);
        sb_t e;
        req   = 1'b1;
        we    = w;
        addr  = {22'b0, a};
        be    = b;
        wdata = d;
        e.chk  = chk;
        e.exp  = exp;
        e.cyc  = cyc + 1;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        be    = '0;
        wdata = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus(1'b1, a, 4'hF, d, 1'b0, 32'd0, "write");
    endtask

    task automatic wrb(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        bus(1'b1, a, b, d, 1'b0, 32'd0, "write_be");
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string name);
        bus(1'b0, a, 4'h0, 32'd0, 1'b1, exp, name);
    endtask

    task automatic expect_pwm(input int ch, input int n, input int start, input int period,
                              input int duty, input bit inv);
        bit exp;
        for (int i = 0; i < n; i++) begin
            exp = (((start + i) % (period + 1)) < duty) ^ inv;
            check($sformatf("pwm_ch%0d_step%0d", ch, i), {31'b0, pwm[ch]}, {31'b0, exp});
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < 100; i++) begin
            check("rst_pwm_idle", 32'(pwm), 32'd0);
            @(negedge clk);
        end
        rd(10'h000, 32'd0, "rst_period0");
        rd(10'h004, 32'd0, "rst_duty0");
        rd(10'h008, 32'd0, "rst_ctrl0");
        rd(10'h00C, 32'd0, "rst_count0");
        rd(10'h0B0, 32'd0, "rst_period11");
        rd(10'h3F0, 32'd0, "rst_irq_status");

        // ch0: 3 high / 7 low, repeating every 10 cycles
        wr(10'h000, 32'd9);
        wr(10'h004, 32'd3);
        wr(10'h008, 32'd1);
        expect_pwm(0, 30, 0, 9, 3, 1'b0);

        // ch2: duty change mid-period only applies from the next period
        wr(10'h020, 32'd9);
        wr(10'h024, 32'd3);
        wr(10'h028, 32'd1);
        expect_pwm(2, 3, 0, 9, 3, 1'b0);
        wr(10'h024, 32'd7);
        rd(10'h024, 32'd7, "ch2_duty_readback");
        expect_pwm(2, 5, 5, 9, 3, 1'b0);
        expect_pwm(2, 23, 0, 9, 7, 1'b0);
        rd(10'h02C, 32'd3, "ch2_count_live");

        // ch1: inverted with zero duty, then disabled with INV held
        wr(10'h014, 32'd0);
        wr(10'h018, 32'd3);
        expect_pwm(1, 15, 0, 0, 0, 1'b1);
        wr(10'h018, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("ch1_disabled_inv", {31'b0, pwm[1]}, 32'd1);
            @(negedge clk);
        end
        rd(10'h01C, 32'd0, "ch1_count_disabled");
        rd(10'h018, 32'd2, "ch1_ctrl_readback");

        // ch4: duty beyond period keeps the output high
        wr(10'h040, 32'd2);
        wr(10'h044, 32'd5);
        wr(10'h048, 32'd1);
        expect_pwm(4, 10, 0, 2, 5, 1'b0);

        // Byte lanes, width truncation, out-of-range channel
        wrb(10'h030, 32'h0000_1234, 4'b0001);
        rd(10'h030, 32'h0000_0034, "ch3_period_be0");
        wrb(10'h034, 32'h0000_ABCD, 4'b0010);
        rd(10'h034, 32'h0000_AB00, "ch3_duty_be1");
        wr(10'h030, 32'hFFFF_FFFF);
        rd(10'h030, 32'h0000_FFFF, "ch3_period_trunc");
        wr(10'h0C0, 32'h55);
        rd(10'h0C0, 32'd0, "ch12_period_dropped");
        rd(10'h040, 32'd2, "ch4_period_no_alias");
        rd(10'h000, 32'd9, "ch0_period_kept");

`ifdef PWM_IRQ_EN
        wr(10'h050, 32'd4);
        wr(10'h058, 32'd5);
        rd(10'h058, 32'd5, "ch5_ctrl_irq_en");
        // phase is now 1; wrap at phase 4
        for (int i = 0; i < 4; i++) begin
            check("irq_low_before_wrap", {31'b0, irq}, 32'd0);
            @(negedge clk);
        end
        check("irq_high_after_wrap", {31'b0, irq}, 32'd1);
        rd(10'h3F0, 32'h20, "irq_status_set");
        wr(10'h3F0, 32'h20);
        for (int i = 0; i < 3; i++) begin
            check("irq_low_after_clear", {31'b0, irq}, 32'd0);
            @(negedge clk);
        end
        check("irq_high_next_wrap", {31'b0, irq}, 32'd1);
`else
        wr(10'h068, 32'd7);
        rd(10'h068, 32'd3, "ch6_ctrl_no_irq_bit");
        rd(10'h3F0, 32'd0, "irq_status_absent");
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
